// File: rtl/rtc_lectura_captura_pkg.sv
// Shared constants for the RTC read-capture block: FSM encoding, register
// indices within one read frame and the default last index.
package rtc_lectura_captura_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_COMMIT  = 2'd3;

  localparam int IDX_SEG    = 0;
  localparam int IDX_MIN    = 1;
  localparam int IDX_HORA   = 2;
  localparam int IDX_DIA    = 3;
  localparam int IDX_MES    = 4;
  localparam int IDX_ANIO   = 5;
  localparam int IDX_DIASEM = 6;

  localparam int NUM_IDX      = 7;
  localparam int DEF_LAST_IDX = 6;

endpackage

// File: rtl/rtc_lectura_captura_if.sv
// Bus bundle between the RTC timing controller and the capture block:
// strobes, address index and read data in, committed time registers out.
interface rtc_lectura_captura_if #(
  parameter int DATA_W = 8
) ();

  logic              CSL;
  logic              RDL;
  logic              ADL;
  logic [3:0]        rd_flags;
  logic [DATA_W-1:0] Dato_In;

  logic [DATA_W-1:0] Seg;
  logic [DATA_W-1:0] Min;
  logic [DATA_W-1:0] Hora;
  logic [DATA_W-1:0] Dia;
  logic [DATA_W-1:0] Mes;
  logic [DATA_W-1:0] Anio;
  logic [DATA_W-1:0] DiaSem;
  logic              Frame_Done;
  logic              Frame_Abort;
  logic              BCD_Err;

  modport master (
    output CSL, RDL, ADL, rd_flags, Dato_In,
    input  Seg, Min, Hora, Dia, Mes, Anio, DiaSem,
    input  Frame_Done, Frame_Abort, BCD_Err
  );

  modport slave (
    input  CSL, RDL, ADL, rd_flags, Dato_In,
    output Seg, Min, Hora, Dia, Mes, Anio, DiaSem,
    output Frame_Done, Frame_Abort, BCD_Err
  );

endinterface

// File: rtl/rtc_lectura_captura_bcd_chk.sv
// Combinational BCD validity check of one byte: flags any nibble above 9.
module bcd_chk #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_byte,
  output logic              o_err
);

  // OR of per-nibble range violations
  always_comb begin
    o_err = 1'b0;
    for (int i = 0; i < DATA_W / 4; i++) begin
      o_err = o_err | (i_byte[i*4 +: 4] > 4'd9);
    end
  end

endmodule

// File: rtl/rtc_lectura_captura.sv
// Captures one RTC read frame into shadow registers and commits it atomically.
// Optional BCD validation of the committed frame is enabled by RTC_BCD_CHECK_EN.
module rtc_lectura_captura
  import rtc_lectura_captura_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LAST_IDX = DEF_LAST_IDX
) (
  input  logic                  Clk,
  input  logic                  Reset,
  rtc_lectura_captura_if.slave  bus
);

  localparam logic [3:0]        C_LAST = 4'(LAST_IDX);
  localparam logic [LAST_IDX:0] C_FULL = '1;

  logic                r_rdl;
  logic [DATA_W-1:0]   r_dato_lat;
  logic [DATA_W-1:0]   r_shadow [0:NUM_IDX-1];
  logic [DATA_W-1:0]   r_out    [0:NUM_IDX-1];
  logic [LAST_IDX:0]   r_mask;
  logic [3:0]          r_prev_idx;
  logic [1:0]          r_state;
  logic                r_done;
  logic                r_abort;

  logic                w_capture;
  logic                w_valid;
  logic                w_is_last;
  logic                w_full;
  logic                w_abort_cap;
  logic                w_commit;
  logic                w_bcd_bad;
  logic [2:0]          w_idx;
  logic [LAST_IDX:0]   w_onehot;
  logic [LAST_IDX:0]   w_new_mask;
  logic [1:0]          w_state_nxt;

  // A capture is the rising edge of RDL while the chip is selected
  assign w_capture   = !r_rdl && bus.RDL && !bus.CSL;
  assign w_valid     = w_capture && (bus.rd_flags <= C_LAST) && (r_state != ST_COMMIT);
  assign w_idx       = bus.rd_flags[2:0];
  assign w_is_last   = (bus.rd_flags == C_LAST);
  assign w_full      = (w_new_mask == C_FULL);
  assign w_abort_cap = w_valid && w_is_last && !w_full;
  assign w_commit    = (r_state == ST_COMMIT) && !w_bcd_bad;

  always_comb begin
    for (int i = 0; i <= LAST_IDX; i++) begin
      w_onehot[i] = (bus.rd_flags == 4'(i));
    end
  end

  // An index lower than the previous one starts a fresh frame
  always_comb begin
    if (bus.rd_flags < r_prev_idx) begin
      w_new_mask = w_onehot;
    end else begin
      w_new_mask = r_mask | w_onehot;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_ARMED, ST_CAPTURE: begin
        if (w_valid) begin
          if (w_is_last) begin
            w_state_nxt = w_full ? ST_COMMIT : ST_ARMED;
          end else begin
            w_state_nxt = ST_CAPTURE;
          end
        end else if (r_state == ST_IDLE && !bus.CSL) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_rdl      <= 1'b1;
      r_dato_lat <= '0;
      r_mask     <= '0;
      r_prev_idx <= 4'd0;
      r_state    <= ST_IDLE;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_rdl   <= bus.RDL;
      r_state <= w_state_nxt;
      if (!bus.CSL && !bus.RDL && bus.ADL) begin
        r_dato_lat <= bus.Dato_In;
      end
      if (w_valid) begin
        r_prev_idx <= bus.rd_flags;
      end
      if (r_state == ST_COMMIT) begin
        r_mask <= '0;
      end else if (w_valid) begin
        r_mask <= w_abort_cap ? '0 : w_new_mask;
      end
      r_done  <= w_commit;
      r_abort <= w_abort_cap || ((r_state == ST_COMMIT) && w_bcd_bad);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_IDX; i++) begin
        r_shadow[i] <= '0;
        r_out[i]    <= '0;
      end
    end else begin
      if (w_valid) begin
        r_shadow[w_idx] <= r_dato_lat;
      end
      if (w_commit) begin
        for (int i = 0; i < NUM_IDX; i++) begin
          r_out[i] <= r_shadow[i];
        end
      end
    end
  end

`ifdef RTC_BCD_CHECK_EN
  logic [NUM_IDX-1:0] w_nib_err;
  logic               r_bcd_err;

  for (genvar g = 0; g < NUM_IDX; g++) begin : g_bcd
    bcd_chk #(.DATA_W(DATA_W)) u_bcd_chk (
      .i_byte (r_shadow[g]),
      .o_err  (w_nib_err[g])
    );
  end

  assign w_bcd_bad = |w_nib_err;

  // Sticky until reset
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_bcd_err <= 1'b0;
    end else if ((r_state == ST_COMMIT) && w_bcd_bad) begin
      r_bcd_err <= 1'b1;
    end
  end

  assign bus.BCD_Err = r_bcd_err;
`else
  assign w_bcd_bad   = 1'b0;
  assign bus.BCD_Err = 1'b0;
`endif

  assign bus.Seg         = r_out[IDX_SEG];
  assign bus.Min         = r_out[IDX_MIN];
  assign bus.Hora        = r_out[IDX_HORA];
  assign bus.Dia         = r_out[IDX_DIA];
  assign bus.Mes         = r_out[IDX_MES];
  assign bus.Anio        = r_out[IDX_ANIO];
  assign bus.DiaSem      = r_out[IDX_DIASEM];
  assign bus.Frame_Done  = r_done;
  assign bus.Frame_Abort = r_abort;

endmodule

// File: tb/tb_rtc_lectura_captura.sv
// Directed scoreboard bench for rtc_lectura_captura; expectations follow
// RTC_BCD_CHECK_EN the same way the design does.
module tb_rtc_lectura_captura;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rtc_lectura_captura_if #(.DATA_W(8)) bus ();

  rtc_lectura_captura #(.DATA_W(8), .LAST_IDX(6)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic            is_done;
    logic [6:0][7:0] vals;
  } exp_t;

  int              n_checks = 0;
  int              n_errors = 0;
  exp_t            sb[$];
  logic [6:0][7:0] m_shadow;
  logic [6:0][7:0] m_out;
  logic [6:0]      m_mask;
  logic [3:0]      m_prev;
  logic            prev_done;
  logic [6:0][7:0] prev_out;

  function automatic logic [6:0][7:0] observed();
    return {bus.DiaSem, bus.Anio, bus.Mes, bus.Dia, bus.Hora, bus.Min, bus.Seg};
  endfunction

  function automatic logic has_bad_nibble(input logic [6:0][7:0] v);
    logic bad = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (v[i][7:4] > 4'd9 || v[i][3:0] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_shadow = '0;
    m_out    = '0;
    m_mask   = '0;
    m_prev   = 4'd0;
    sb.delete();
  endtask

  // Reference behaviour of one accepted capture; pushes the expected pulse
  task automatic model_capture(input logic [3:0] idx, input logic [7:0] d);
    exp_t e;
    if (idx > 4'd6) return;
    if (idx < m_prev) m_mask = '0;
    m_mask[idx]   = 1'b1;
    m_shadow[idx] = d;
    m_prev        = idx;
    if (idx == 4'd6) begin
      e.is_done = 1'b0;
      if (&m_mask) begin
`ifdef RTC_BCD_CHECK_EN
        if (!has_bad_nibble(m_shadow)) begin
          m_out     = m_shadow;
          e.is_done = 1'b1;
        end
`else
        m_out     = m_shadow;
        e.is_done = 1'b1;
`endif
      end
      e.vals = m_out;
      sb.push_back(e);
      m_mask = '0;
    end
  endtask

  task automatic access(input logic [3:0] idx, input logic [7:0] d, input logic csl);
    @(negedge clk);
    bus.CSL      = csl;
    bus.ADL      = 1'b1;
    bus.rd_flags = idx;
    bus.Dato_In  = d;
    bus.RDL      = 1'b0;
    @(negedge clk);
    bus.RDL = 1'b1;
    @(posedge clk);
    if (!csl) model_capture(idx, d);
    @(negedge clk);
    bus.ADL = 1'b0;
    bus.CSL = 1'b0;
  endtask

  task automatic frame(input logic [6:0][7:0] v);
    for (int i = 0; i < 7; i++) access(4'(i), v[i], 1'b0);
    repeat (2) @(negedge clk);
  endtask

  // Pulse scoreboard and output-stability monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_done = 1'b0;
      prev_out  = observed();
    end else begin
      chk("done_abort_excl", {63'd0, bus.Frame_Done & bus.Frame_Abort}, 64'd0);
      if (bus.Frame_Done || bus.Frame_Abort) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {62'd0, bus.Frame_Done, bus.Frame_Abort}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", {63'd0, bus.Frame_Done}, {63'd0, e.is_done});
          chk("pulse_outputs", {8'd0, observed()}, {8'd0, e.vals});
        end
      end
      chk("single_done", {63'd0, prev_done & bus.Frame_Done}, 64'd0);
      if (!bus.Frame_Done) chk("outputs_stable", {8'd0, observed()}, {8'd0, prev_out});
      prev_done = bus.Frame_Done;
      prev_out  = observed();
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.CSL = 1'b1; bus.RDL = 1'b1; bus.ADL = 1'b0;
    bus.rd_flags = 4'd0; bus.Dato_In = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_outputs", {8'd0, observed()}, 64'd0);
    chk("rst_done",  {63'd0, bus.Frame_Done},  64'd0);
    chk("rst_abort", {63'd0, bus.Frame_Abort}, 64'd0);
    chk("rst_bcd",   {63'd0, bus.BCD_Err},     64'd0);

    // Full frame
    frame({8'h02, 8'h16, 8'h04, 8'h17, 8'h12, 8'h30, 8'h45});
    chk("full_seg",    {56'd0, bus.Seg},    64'h45);
    chk("full_diasem", {56'd0, bus.DiaSem}, 64'h02);
    chk("full_all", {8'd0, observed()}, {8'd0, 8'h02, 8'h16, 8'h04, 8'h17, 8'h12, 8'h30, 8'h45});

    // Gap: index 3 missing
    access(4'd0, 8'h99, 1'b0); access(4'd1, 8'h99, 1'b0); access(4'd2, 8'h99, 1'b0);
    access(4'd4, 8'h99, 1'b0); access(4'd5, 8'h99, 1'b0); access(4'd6, 8'h99, 1'b0);
    repeat (2) @(negedge clk);
    chk("gap_hold", {8'd0, observed()}, {8'd0, 8'h02, 8'h16, 8'h04, 8'h17, 8'h12, 8'h30, 8'h45});

    // Wrap after idx2, plus a repeated idx1
    access(4'd0, 8'h21, 1'b0); access(4'd1, 8'h22, 1'b0); access(4'd2, 8'h23, 1'b0);
    access(4'd0, 8'h33, 1'b0); access(4'd1, 8'h01, 1'b0); access(4'd1, 8'h34, 1'b0);
    for (int i = 2; i < 7; i++) access(4'(i), 8'h33 + 8'(i), 1'b0);
    repeat (2) @(negedge clk);
    chk("wrap_seg",    {56'd0, bus.Seg},    64'h33);
    chk("wrap_min",    {56'd0, bus.Min},    64'h34);
    chk("wrap_diasem", {56'd0, bus.DiaSem}, 64'h39);

    // RDL edge with CSL=1 must not fill the gap at index 3
    for (int i = 0; i < 3; i++) access(4'(i), 8'h50 + 8'(i), 1'b0);
    access(4'd3, 8'h53, 1'b1);
    access(4'd4, 8'h54, 1'b0); access(4'd5, 8'h55, 1'b0); access(4'd6, 8'h56, 1'b0);
    repeat (2) @(negedge clk);
    chk("ign_csl_hold", {56'd0, bus.Seg}, 64'h33);

    // Out-of-range index 9 must not disturb the frame
    for (int i = 0; i < 6; i++) access(4'(i), 8'h60 + 8'(i), 1'b0);
    access(4'd9, 8'h69, 1'b0);
    access(4'd6, 8'h66, 1'b0);
    repeat (2) @(negedge clk);
    chk("ign_idx9_seg",    {56'd0, bus.Seg},    64'h60);
    chk("ign_idx9_diasem", {56'd0, bus.DiaSem}, 64'h66);

    // Reset mid-frame, then a full frame of 0x11
    for (int i = 0; i < 4; i++) access(4'(i), 8'h77, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("midrst_outputs", {8'd0, observed()}, 64'd0);
    chk("midrst_abort", {63'd0, bus.Frame_Abort}, 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_outputs", {8'd0, observed()}, 64'd0);
    frame({7{8'h11}});
    chk("rst_frame_all", {8'd0, observed()}, {8'd0, {7{8'h11}}});

    // Non-BCD seconds byte
    frame({8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h5A});
`ifdef RTC_BCD_CHECK_EN
    chk("bcd_seg_hold", {56'd0, bus.Seg},     64'h11);
    chk("bcd_err",      {63'd0, bus.BCD_Err}, 64'd1);
`else
    chk("bcd_seg_commit", {56'd0, bus.Seg},     64'h5A);
    chk("bcd_err_tied",   {63'd0, bus.BCD_Err}, 64'd0);
`endif

    repeat (4) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
